// File: rtl/systolic_pkg.sv
// systolic_pkg: shared widths, default array size and feeder state enum for the systolic MAC array
package systolic_pkg;
  localparam int N_DEF  = 4;
  localparam int A_W    = 8;
  localparam int LEFT_W = 9;
  localparam int TOP_W  = 8;
  localparam int ACC_W  = 32;
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, FLUSH, DONE} feeder_state_e;
  function automatic logic [LEFT_W-1:0] sext_a(input logic [A_W-1:0] a);
    return {a[A_W-1], a};
  endfunction
endpackage

// File: rtl/systolic_feeder_skew_line.sv
// skew_line: D-stage register delay line with sync reset, pass-through when D=0
//   clk, reset : clock, synchronous active-high reset (zeroes every stage)
//   d_i        : W-bit input
//   q_o        : d_i delayed by D cycles
module skew_line #(
  parameter int W = 8,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  if (D == 0) begin : g_pass
    logic unused_cr;
    assign unused_cr = clk ^ reset;
    assign q_o = d_i;
  end else begin : g_reg
    logic [W-1:0] r_q [D];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < D; s++) r_q[s] <= '0;
      end else begin
        r_q[0] <= d_i;
        for (int s = 1; s < D; s++) r_q[s] <= r_q[s-1];
      end
    end
    assign q_o = r_q[D-1];
  end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: fetches K operand words and skews them onto the left/top edges of an NxN systolic array
//   clk, reset            : clock, synchronous active-high reset
//   start, k_len          : begin a tile of depth k_len (sampled in IDLE only)
//   input_offset          : signed offset added to A lanes (only with FEEDER_OFFSET_EN defined)
//   buf_rd_o, buf_addr_o  : shared A/B buffer read strobe and address
//   a_data_i, b_data_i    : buffer data, valid one cycle after the read
//   pe_rst_o              : accumulator clear to all PEs
//   left_o, top_o         : skewed edge operands, lane i delayed by i cycles
//   busy, done            : tile in progress, one-cycle completion pulse
// Build option: FEEDER_OFFSET_EN enables the A-lane offset adder.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int KW = 16,
  parameter int AW = 16
) (
  input  logic                si_dummy_unused_never = 1'b0,
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic [LEFT_W-1:0]   input_offset,
  output logic                buf_rd_o,
  output logic [AW-1:0]       buf_addr_o,
  input  logic [N*A_W-1:0]    a_data_i,
  input  logic [N*TOP_W-1:0]  b_data_i,
  output logic                pe_rst_o,
  output logic [N*LEFT_W-1:0] left_o,
  output logic [N*TOP_W-1:0]  top_o,
  output logic                busy,
  output logic                done
);
  feeder_state_e state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d, k_q;
  logic rd_q;
  logic [N*LEFT_W-1:0] a_q, a_d;
  logic [N*TOP_W-1:0] b_q, b_d;
  logic take;
  assign take = (state_q == IDLE) && start;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // cnt_q restarts at 0 on every state change, so it indexes k in FETCH and flush cycles in FLUSH
  always_comb begin
    state_d = state_q == IDLE  ? (start ? CLEAR : IDLE) :
              state_q == CLEAR ? (k_q == '0 ? DONE : FETCH) :
              state_q == FETCH ? (cnt_q == k_q - KW'(1) ? FLUSH : FETCH) :
              state_q == FLUSH ? (cnt_q == KW'(2*N-1) ? DONE : FLUSH) : IDLE;
    cnt_d = state_d == state_q ? cnt_q + KW'(1) : '0;
  end
  always_comb begin
    buf_rd_o   = state_q == FETCH;
    buf_addr_o = buf_rd_o ? AW'(cnt_q) : '0;
    pe_rst_o   = state_q == CLEAR;
    busy       = state_q != IDLE;
    done       = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q  <= '0;
      rd_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      if (take) k_q <= k_len;
      rd_q <= buf_rd_o;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end
`ifdef FEEDER_OFFSET_EN
  logic [LEFT_W-1:0] off_q;
  always_ff @(posedge clk) begin
    if (reset) off_q <= '0;
    else if (take) off_q <= input_offset;
  end
`else
  logic unused_off;
  assign unused_off = ^input_offset;
`endif
  genvar i;
  for (i = 0; i < N; i++) begin : g_lane
    logic [LEFT_W-1:0] a_ext;
`ifdef FEEDER_OFFSET_EN
    assign a_ext = sext_a(a_data_i[i*A_W +: A_W]) + off_q;
`else
    assign a_ext = sext_a(a_data_i[i*A_W +: A_W]);
`endif
    // slots without a read one cycle earlier carry zero so PEs accumulate nothing
    assign a_d[i*LEFT_W +: LEFT_W] = rd_q ? a_ext : '0;
    assign b_d[i*TOP_W +: TOP_W]   = rd_q ? b_data_i[i*TOP_W +: TOP_W] : '0;
    skew_line #(.W(LEFT_W), .D(i)) u_left (
      .clk(clk), .reset(reset),
      .d_i(a_q[i*LEFT_W +: LEFT_W]), .q_o(left_o[i*LEFT_W +: LEFT_W])
    );
    skew_line #(.W(TOP_W), .D(i)) u_top (
      .clk(clk), .reset(reset),
      .d_i(b_q[i*TOP_W +: TOP_W]), .q_o(top_o[i*TOP_W +: TOP_W])
    );
  end
  logic unused_si;
  assign unused_si = si_dummy_unused_never;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed self-checking bench with an NxN PE accumulation model
module tb_systolic_feeder;
  localparam int N = 4, KW = 16, AW = 16;
`ifdef FEEDER_OFFSET_EN
  localparam int LV = -1;
`else
  localparam int LV = -128;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [8:0] input_offset = '0;
  logic buf_rd_o, pe_rst_o, busy, done;
  logic [AW-1:0] buf_addr_o;
  logic [N*8-1:0] a_data_i = '0, b_data_i = '0, top_o;
  logic [N*9-1:0] left_o;
  always #5 clk = ~clk;
  systolic_feeder #(.N(N), .KW(KW), .AW(AW)) dut (
    .si_dummy_unused_never(1'b0),
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .input_offset(input_offset),
    .buf_rd_o(buf_rd_o), .buf_addr_o(buf_addr_o), .a_data_i(a_data_i), .b_data_i(b_data_i),
    .pe_rst_o(pe_rst_o), .left_o(left_o), .top_o(top_o), .busy(busy), .done(done)
  );
  int checks = 0, failures = 0, cyc = 0, s = 0, tb = 0, rstc = -1, donec = -1, ndone = 0, pk = 0;
  bit pend = 1'b0;
  int amem[8][N], bmem[8][N], la[64][N], ta[64][N], eacc[N][N];
  int addrq[$];
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      a_data_i[i*8 +: 8] = pend ? 8'(amem[pk][i]) : 8'hA5;
      b_data_i[i*8 +: 8] = pend ? 8'(bmem[pk][i]) : 8'h5A;
    end
    if (pe_rst_o) begin
      tb = cyc;
      rstc = cyc;
      for (int t = 0; t < 64; t++)
        for (int i = 0; i < N; i++) begin
          la[t][i] = 0;
          ta[t][i] = 0;
        end
    end
    if (cyc - tb < 64)
      for (int i = 0; i < N; i++) begin
        la[cyc-tb][i] = int'($signed(left_o[i*9 +: 9]));
        ta[cyc-tb][i] = int'($signed(top_o[i*8 +: 8]));
      end
    pend = buf_rd_o;
    pk = int'(buf_addr_o) & 7;
    if (buf_rd_o) addrq.push_back(int'(buf_addr_o));
    if (done) begin
      ndone++;
      donec = cyc;
    end
  endtask
  task automatic run_tile(input int k, input int off, input int sp, input int rs);
    addrq.delete();
    ndone = 0;
    donec = -1;
    rstc = -1;
    k_len = KW'(k);
    input_offset = 9'(off);
    start = 1'b1;
    s = cyc;
    for (int n = 0; n < k + 2*N + 8; n++) begin
      tick();
      if (cyc - s == rs + 1) begin
        chk("rst_outputs", {buf_rd_o, buf_addr_o, pe_rst_o, left_o, top_o, done}, '0);
        chk("rst_busy", busy, 1'b0);
      end
      start = (cyc - s == sp);
      reset = (cyc - s == rs);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask
  task automatic check_acc(input string nm);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int acc = 0;
        for (int t = 0; t < 64; t++)
          if (t >= i && t >= j) acc += la[t-j][i] * ta[t-i][j];
        chk($sformatf("%s_acc%0d%0d", nm, i, j), acc, eacc[i][j]);
      end
  endtask
  task automatic load_t1();
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < N; i++) begin
        amem[k][i] = 2;
        bmem[k][i] = 3;
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) eacc[i][j] = 6;
  endtask
  initial begin
    int f0, f3;
    repeat (3) tick();
    chk("reset_outputs", {buf_rd_o, buf_addr_o, pe_rst_o, left_o, top_o, busy, done}, '0);
    reset = 1'b0;
    tick();
    load_t1();
    run_tile(1, 0, -1, -1);
    chk("t1_done_cycle", donec - s, 11);
    chk("t1_done_count", ndone, 1);
    chk("t1_pe_rst_cycle", rstc - s, 1);
    chk("t1_left0", la[3][0], 2);
    check_acc("t1");
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < N; i++) begin
        amem[k][i] = (i == k) ? 1 : 0;
        bmem[k][i] = 4*k + i + 1;
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) eacc[i][j] = 4*i + j + 1;
    run_tile(4, 0, -1, -1);
    chk("t2_done_cycle", donec - s, 14);
    f0 = -1;
    f3 = -1;
    for (int t = 63; t >= 0; t--) begin
      if (ta[t][0] != 0) f0 = t;
      if (ta[t][3] != 0) f3 = t;
    end
    chk("t2_top0_first", f0, 3);
    chk("t2_lane3_skew", f3 - f0, 3);
    check_acc("t2");
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < N; i++) amem[k][i] = -128;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) eacc[i][j] = LV * (2*j + 6);
    run_tile(2, 127, -1, -1);
    chk("t3_left0", la[3][0], LV);
    chk("t3_left2", la[5][2], LV);
    chk("t3_done_cycle", donec - s, 12);
    check_acc("t3");
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) eacc[i][j] = 0;
    run_tile(0, 0, -1, -1);
    chk("t4_pe_rst_cycle", rstc - s, 1);
    chk("t4_done_cycle", donec - s, 2);
    chk("t4_reads", addrq.size(), 0);
    check_acc("t4");
    run_tile(3, 0, 5, -1);
    chk("t5_done_cycle", donec - s, 13);
    chk("t5_done_count", ndone, 1);
    chk("t5_reads", addrq.size(), 3);
    for (int n = 0; n < 3; n++)
      chk($sformatf("t5_addr%0d", n), addrq.size() > n ? addrq[n] : -1, n);
    run_tile(4, 0, -1, 6);
    chk("t6_no_done", ndone, 0);
    load_t1();
    run_tile(1, 0, -1, -1);
    chk("t6b_done_cycle", donec - s, 11);
    chk("t6b_done_count", ndone, 1);
    check_acc("t6b");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand transmitter for the N×N systolic MAC array. On `start` it clears the PE accumulators, reads K operand words from the A and B buffers, and skews them onto the array's left edge (9-bit signed, offset-adjusted) and top edge (8-bit signed). Lane i is delayed by i cycles, so PE(i,j) receives A[i][k] and B[k][j] in the same cycle. A `done` pulse fires once the accumulator of the last PE, PE(N-1,N-1), holds its final value.

## Interface
Parameters:
- `N`, 4, array dimension (lanes per edge)
- `KW`, 16, width of depth count `k_len`
- `AW`, 16, buffer address width (≥ KW)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a tile; sampled only in IDLE
- `k_len`  in  KW  reduction depth K; sampled with `start`
- `input_offset`  in  9  signed offset added to A lanes; sampled with `start`
- `buf_rd_o`  out  1  buffer read strobe
- `buf_addr_o`  out  AW  read address k, shared by A and B buffers
- `a_data_i`  in  N*8  lane i = A[i][k], signed, valid 1 cycle after read
- `b_data_i`  in  N*8  lane j = B[k][j], signed, valid 1 cycle after read
- `pe_rst_o`  out  1  accumulator clear to all PEs
- `left_o`  out  N*9  left-edge operands, lane i → row i
- `top_o`  out  N*8  top-edge operands, lane j → column j
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse: all PE accumulators final

## Operation
- FSM states: IDLE → CLEAR → FETCH → FLUSH → DONE → IDLE.
- IDLE: outputs idle. `start` latches `k_len` and `input_offset`.
  - If K = 0, the next state is CLEAR, then DONE directly.
- CLEAR: one cycle, `pe_rst_o`=1.
- FETCH: K cycles. `buf_rd_o`=1 and `buf_addr_o`=k for k = 0..K-1.
- FLUSH: exactly 2N cycles, `buf_rd_o`=0. Skew pipelines drain.
- DONE: one cycle, `done`=1. Then IDLE.
- Returned data is tagged valid when it is 1 cycle behind a read. It enters an output register, then the lane-i skew line (delay i).
- Invalid slots drive 0 on both edges, so no spurious products accumulate.
- A lane value is sign-extend(A[i][k]) + `input_offset`, 9-bit, wrapping. `input_offset` ∈ [-128,127] gives no overflow.
- `start` while `busy` is ignored. The latched K and offset are held for the whole tile.
- `reset` at any time, including mid-tile:
  - state goes to IDLE;
  - skew lines are zeroed;
  - all outputs go to 0;
  - no `done` is issued.
- Reset values: `buf_rd_o`=0, `buf_addr_o`=0, `pe_rst_o`=0, `left_o`=0, `top_o`=0, `busy`=0, `done`=0.

## Timing
Cycle S is the cycle in which `start` is sampled in IDLE.
- S+1: `pe_rst_o`=1, `busy`=1.
- S+2+k: `buf_addr_o`=k, for k < K.
- S+3+k: buffer data for k is valid.
- S+4+k+i: `left_o` lane i = A[i][k]+offset.
- S+4+k+j: `top_o` lane j = B[k][j].
- PE(i,j) sees operand pair k in cycle S+4+k+i+j.
  - It arrives through i+j PE forwarding registers on the combined path.
- Last product lands in PE(N-1,N-1) at the end of cycle S+K+2N+1.
- `done`=1 in cycle S+K+2N+2. `busy` falls at S+K+2N+3. A new `start` is accepted in that cycle.
- K=0: `pe_rst_o` at S+1, `done` at S+2.
- Tile latency, start to done: K+2N+2 cycles.

## Configuration
- `FEEDER_OFFSET_EN` defined:
  - `input_offset` is latched and added to every A lane.
- Not defined:
  - `input_offset` port is present but ignored;
  - left lanes carry sign-extended A only;
  - the adder is removed.
- Timing is identical in both builds.

## Structure
- Shared package `systolic_pkg`:
  - `N` default;
  - operand widths (`A_W`=8, `LEFT_W`=9, `TOP_W`=8, `ACC_W`=32);
  - feeder state enum (IDLE, CLEAR, FETCH, FLUSH, DONE).
- Sub-module `skew_line`: parameterized width and depth D, a D-stage register chain with synchronous reset and a pass-through when D=0.
  - Instantiated once per left lane and once per top lane.

## Test plan
- N=4, K=1, A lanes all 2, B lanes all 3, offset 0 → PE model accs all 6; `done` at S+11.
- N=4, K=4, A=identity, B=[1..16] row-major, offset 0 → acc(i,j)=B[i][j]. Lane-3 operands skewed exactly 3 cycles after lane 0.
- N=4, K=2, A lanes all -128, offset 127 (macro on) → left lanes = -1; acc(i,j) = -(B[0][j]+B[1][j]). Macro off: left lanes = -128.
- K=0 → `pe_rst_o` at S+1, `done` at S+2, no `buf_rd_o`, all accs 0.
- `start` pulsed at S+5 during K=3 tile → ignored; single `done` at S+13; addresses 0,1,2 only.
- `reset` asserted at S+6 of a K=4 tile → next cycle all outputs 0 and state IDLE; no `done`. A following K=1 tile completes normally.
